trace_capture: RTL and testbench
================================

TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 Parameter WIDTH, default 16, is the bits per channel sample.
REQ-002 Parameter NCH, default 2, is the number of channels captured per sample.
REQ-003 Parameter DEPTH, default 16, is the buffer entries; it SHALL be a power of two, at least 4.
REQ-004 Parameter POST, default DEPTH/2, is the samples captured after the trigger; 1 <= POST <= DEPTH-1.
REQ-005 Clock  in  1  single clock; all state updates on the rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 cap_data  in  NCH*WIDTH  sample; channel k is bits [k*WIDTH +: WIDTH].
REQ-008 cap_valid  in  1  qualifies cap_data for this cycle.
REQ-009 arm  in  1  single-cycle pulse that starts a capture.
REQ-010 abort  in  1  single-cycle pulse that cancels a capture.
REQ-011 trig_ch  in  clog2(NCH) (min 1)  channel compared for the trigger.
REQ-012 trig_value, trig_mask  in  WIDTH each  trigger pattern and care mask.
REQ-013 rd_addr  in  clog2(DEPTH)  readout index, 0 = oldest sample.
REQ-014 rd_data  out  NCH*WIDTH  registered readout data.
REQ-015 state  out  2  IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-016 done  out  1  high while in DONE.
REQ-017 wrapped  out  1  buffer has been overwritten at least once in this capture.
REQ-018 sample_count  out  clog2(DEPTH)+1  valid entries, saturating at DEPTH.
REQ-019 trig_index  out  clog2(DEPTH)  readout index of the trigger sample.

Function
REQ-020 The block SHALL write a sample only when cap_valid=1 in ARMED or POST; writes go to wr_ptr, which then increments modulo DEPTH.
REQ-021 IDLE: arm -> ARMED; wr_ptr, sample_count, wrapped and post counter cleared in that same cycle.
REQ-022 ARMED: a trigger occurs when cap_valid=1 and ((channel trig_ch ^ trig_value) & trig_mask)==0; the triggering sample SHALL be written, and state -> POST.
REQ-023 A trigger condition in the same cycle as arm SHALL be ignored; sampling begins the cycle after arm.
REQ-024 POST: count written samples; after the POST-th post-trigger write, state -> DONE in the same edge; trigger matches in POST are ignored.
REQ-025 DONE: no writes; arm restarts as in REQ-021; state holds otherwise.
REQ-026 abort in ARMED or POST -> IDLE, done=0; abort takes priority over a trigger or arm in the same cycle; abort in IDLE or DONE has no effect.
REQ-027 arm in ARMED or POST SHALL be ignored.
REQ-028 wrapped SHALL set on the first write when wr_ptr=DEPTH-1.
REQ-029 Readout physical address = (wrapped ? wr_ptr + rd_addr : rd_addr) mod DEPTH; rd_data is valid one cycle after rd_addr; rd_addr >= sample_count returns unspecified data.
REQ-030 trig_index = (sample_count-1) - POST, valid in DONE.
REQ-031 The buffer SHALL be readable in any state; meaningful only in DONE.

Reset
REQ-032 Reset -> state IDLE; done, wrapped, sample_count, trig_index, wr_ptr, post counter and rd_data all 0.
REQ-033 Reset mid-capture behaves as REQ-032; buffer contents are not cleared.
REQ-034 Reset overrides arm, abort and trigger in the same cycle.

Structure
REQ-035 The state encoding constants SHALL be placed in a shared package (trace_pkg), with the packed-channel slice helper.
REQ-036 Storage SHALL be one sub-module, trace_ram: DEPTH x NCH*WIDTH, one write port, one registered read port, with no reset on the array.
REQ-037 The FSM, pointers and counters SHALL live in trace_capture.

Verification (WIDTH=16, NCH=2, DEPTH=16, POST=8)
REQ-038 Reset asserted for 1 cycle -> state=0, done=0, sample_count=0, rd_data=0.
REQ-039 Arm; ch0 = 0x0000..0x001C on consecutive valid cycles; trigger 0x0014, mask 0xFFFF -> DONE after sample 0x001C; wrapped=1, count=16, trig_index=7; rd_addr 0 -> 0x000D, rd_addr 15 -> 0x001C.
REQ-040 Same setup with trigger 0x0003 -> count=12, wrapped=0, trig_index=3; rd_addr 0 -> 0x0000, rd_addr 11 -> 0x000B.
REQ-041 cap_valid low for 3 cycles during POST -> those cycles not written; DONE is delayed by 3 cycles; contents equal the REQ-039 result.
REQ-042 Reset or abort 2 samples into POST -> IDLE, done=0; a following arm and trigger on 0x0003 reproduces REQ-040.
REQ-043 Trigger pattern present on the arm cycle only -> no trigger; mask 0x00F0 with value 0x0010 triggers on sample 0x0010.

Source files
------------

// File: rtl/trace_pkg.sv
// trace_pkg: definitions shared by the trace capture block.
//   trace_state_t : capture FSM state, encoded as seen on the 'state' port
//                   (IDLE=0, ARMED=1, POST=2, DONE=3).
//   ch_lo()       : bit offset of channel 'ch' inside a packed sample whose
//                   channels are each 'width' bits (channel k at [k*width +: width]).
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    function automatic int ch_lo(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// trace_ram: sample storage for trace_capture.
// DEPTH x DW array with one write port and one registered read port. The
// array itself is never reset; only the read register clears on rst.
// Ports:
//   clk, rst        clock and synchronous active-high reset (read register only)
//   we, waddr, wdata write enable, address and data
//   raddr           read address
//   rdata           registered read data, valid one cycle after raddr
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/trace_capture.sv
// trace_capture: triggered multi-channel trace buffer.
// After 'arm' the block records every valid sample into a circular buffer
// until a masked match on one channel fires the trigger; it then records
// POST further samples and stops in DONE, leaving the pre- and post-trigger
// history readable oldest-first through rd_addr.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cap_data, cap_valid   packed NCH x WIDTH sample and its qualifier
//   arm, abort            start / cancel a capture (single-cycle pulses)
//   trig_ch               channel examined for the trigger
//   trig_value, trig_mask trigger pattern and care mask
//   rd_addr, rd_data      readout index (0 = oldest) and registered data
//   state, done           FSM state and DONE flag
//   wrapped               buffer overwrote itself during this capture
//   sample_count          valid entries, saturates at DEPTH
//   trig_index            readout index of the trigger sample (valid in DONE)
module trace_capture
    import trace_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NCH    = 2,
    parameter int DEPTH  = 16,
    parameter int POST   = DEPTH / 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1,
    localparam int TCW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int DW    = NCH * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    cap_data,
    input  logic             cap_valid,
    input  logic             arm,
    input  logic             abort,
    input  logic [TCW-1:0]   trig_ch,
    input  logic [WIDTH-1:0] trig_value,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [AW-1:0]    rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic [1:0]       state,
    output logic             done,
    output logic             wrapped,
    output logic [CW-1:0]    sample_count,
    output logic [AW-1:0]    trig_index
);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 4)) begin : g_bad_depth
        $error("trace_capture: DEPTH must be a power of two and at least 4");
    end
    if ((POST < 1) || (POST > DEPTH - 1)) begin : g_bad_post
        $error("trace_capture: POST must be in 1..DEPTH-1");
    end

    trace_state_t     state_q, state_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    post_cnt;
    logic [WIDTH-1:0] trig_sample;
    logic             trig_hit;
    logic             wr_en;
    logic             clear;
    logic [CW-1:0]    cnt_inc;
    logic [AW-1:0]    rd_phys;

    // Select the trigger channel out of the packed sample.
    always_comb begin
        trig_sample = '0;
        for (int k = 0; k < NCH; k++) begin
            if (trig_ch == TCW'(k)) begin
                trig_sample = cap_data[ch_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

    assign trig_hit = (((trig_sample ^ trig_value) & trig_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state, write enable and capture-restart strobe. The arm cycle is
    // spent in IDLE/DONE, so a trigger pattern on that cycle is never seen.
    // abort is tested first so it wins over a trigger in the same cycle.
    always_comb begin
        state_nxt = state_q;
        wr_en     = 1'b0;
        clear     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_nxt = ST_ARMED;
                    clear     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cap_valid) begin
                    wr_en = 1'b1;
                    if (trig_hit) begin
                        state_nxt = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                end else if (cap_valid) begin
                    wr_en = 1'b1;
                    if (post_cnt == AW'(POST - 1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign cnt_inc = (sample_count == CW'(DEPTH)) ? sample_count : sample_count + CW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            post_cnt     <= '0;
            sample_count <= '0;
            wrapped      <= 1'b0;
            trig_index   <= '0;
        end else if (clear) begin
            wr_ptr       <= '0;
            post_cnt     <= '0;
            sample_count <= '0;
            wrapped      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr       <= wr_ptr + AW'(1);
                sample_count <= cnt_inc;
                if (wr_ptr == AW'(DEPTH - 1)) begin
                    wrapped <= 1'b1;
                end
            end
            if (wr_en && (state_q == ST_POST)) begin
                post_cnt <= post_cnt + AW'(1);
            end
            // The trigger sample sits POST entries before the newest one.
            if ((state_q == ST_POST) && (state_nxt == ST_DONE)) begin
                trig_index <= AW'(cnt_inc - CW'(POST + 1));
            end
        end
    end

    // Once wrapped, the oldest entry is the one about to be overwritten.
    assign rd_phys = wrapped ? (wr_ptr + rd_addr) : rd_addr;

    trace_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (cap_data),
        .raddr (rd_phys),
        .rdata (rd_data)
    );

    assign state = state_q;
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture (WIDTH=16, NCH=2, DEPTH=16, POST=8).
// A queue-based model of the capture history predicts all outputs; a
// negedge compare process checks them every cycle, and directed scenarios
// pin the model with literal expectations before a randomized phase.
module tb_trace_capture;

    localparam int WIDTH = 16;
    localparam int NCH   = 2;
    localparam int DEPTH = 16;
    localparam int POST  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cap_data = '0;
    logic        cap_valid = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [0:0]  trig_ch = '0;
    logic [15:0] trig_value = '0;
    logic [15:0] trig_mask = '0;
    logic [3:0]  rd_addr = '0;
    logic [31:0] rd_data;
    logic [1:0]  state;
    logic        done;
    logic        wrapped;
    logic [4:0]  sample_count;
    logic [3:0]  trig_index;

    always #5 clk = ~clk;

    trace_capture #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .DEPTH (DEPTH),
        .POST  (POST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cap_data     (cap_data),
        .cap_valid    (cap_valid),
        .arm          (arm),
        .abort        (abort),
        .trig_ch      (trig_ch),
        .trig_value   (trig_value),
        .trig_mask    (trig_mask),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .state        (state),
        .done         (done),
        .wrapped      (wrapped),
        .sample_count (sample_count),
        .trig_index   (trig_index)
    );

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The last DEPTH written samples of the current capture, oldest first,
    // plus the total number written; everything else follows from those.
    int          m_state = 0;
    logic [31:0] m_q[$];
    int          m_nw = 0;
    int          m_post = 0;
    int          m_tidx = 0;
    bit          m_rd_zero = 1'b0;
    bit          m_rd_ok = 1'b0;
    logic [31:0] m_rd_exp = '0;

    function automatic int m_count();
        return (m_nw < DEPTH) ? m_nw : DEPTH;
    endfunction

    function automatic bit m_match(input logic [31:0] d);
        logic [15:0] ch;
        ch = trig_ch[0] ? d[31:16] : d[15:0];
        return ((ch ^ trig_value) & trig_mask) == 16'h0000;
    endfunction

    function automatic void m_write(input logic [31:0] d);
        m_q.push_back(d);
        if (m_q.size() > DEPTH) void'(m_q.pop_front());
        m_nw++;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state   = 0;
            m_q.delete();
            m_nw      = 0;
            m_post    = 0;
            m_tidx    = 0;
            m_rd_zero = 1'b1;
            m_rd_ok   = 1'b0;
        end else begin
            m_rd_zero = 1'b0;
            m_rd_ok   = (m_state == 3) && (int'(rd_addr) < m_count());
            if (m_rd_ok) m_rd_exp = m_q[rd_addr];
            case (m_state)
                0, 3: if (arm) begin
                    m_state = 1;
                    m_q.delete();
                    m_nw    = 0;
                    m_post  = 0;
                end
                1: if (abort) m_state = 0;
                   else if (cap_valid) begin
                       m_write(cap_data);
                       if (m_match(cap_data)) m_state = 2;
                   end
                default: if (abort) m_state = 0;
                   else if (cap_valid) begin
                       m_write(cap_data);
                       m_post++;
                       if (m_post == POST) begin
                           m_state = 3;
                           m_tidx  = m_count() - 1 - POST;
                       end
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("state", 32'(state), 32'(m_state));
            chk("done", 32'(done), 32'(m_state == 3));
            chk("wrapped", 32'(wrapped), 32'(m_nw >= DEPTH));
            chk("sample_count", 32'(sample_count), 32'(m_count()));
            if (m_state == 3) chk("trig_index", 32'(trig_index), 32'(m_tidx));
            if (m_rd_zero) chk("rd_data_reset", rd_data, 32'h0);
            else if (m_rd_ok) chk("rd_data", rd_data, m_rd_exp);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic a, input logic ab, input logic v, input logic [15:0] c0);
        arm       = a;
        abort     = ab;
        cap_valid = v;
        cap_data  = {16'($urandom), c0};
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] addr);
        rd_addr = addr;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic capture(input logic [15:0] tv, input logic [15:0] tm, input int last);
        trig_ch    = 1'b0;
        trig_value = tv;
        trig_mask  = tm;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i <= last; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i));
        cap_valid = 1'b0;
    endtask

    task automatic check_short_capture(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd3);
        chk({tag, "_count"}, 32'(sample_count), 32'd12);
        chk({tag, "_wrapped"}, 32'(wrapped), 32'd0);
        chk({tag, "_tidx"}, 32'(trig_index), 32'd3);
        rd(4'd0);
        chk({tag, "_rd0"}, 32'(rd_data[15:0]), 32'h0000);
        rd(4'd11);
        chk({tag, "_rd11"}, 32'(rd_data[15:0]), 32'h000B);
    endtask

    initial begin
        // Reset held for one cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_tidx", 32'(trig_index), 32'd0);

        // Trigger at 0x14, wraps.
        capture(16'h0014, 16'hFFFF, 16'h1C);
        chk("wrap_state", 32'(state), 32'd3);
        chk("wrap_done", 32'(done), 32'd1);
        chk("wrap_wrapped", 32'(wrapped), 32'd1);
        chk("wrap_count", 32'(sample_count), 32'd16);
        chk("wrap_tidx", 32'(trig_index), 32'd7);
        rd(4'd0);
        chk("wrap_rd0", 32'(rd_data[15:0]), 32'h000D);
        rd(4'd15);
        chk("wrap_rd15", 32'(rd_data[15:0]), 32'h001C);
        rd(4'd7);
        chk("wrap_rd_trig", 32'(rd_data[15:0]), 32'h0014);

        // Trigger at 0x03, no wrap.
        capture(16'h0003, 16'hFFFF, 16'h1C);
        check_short_capture("short");

        // cap_valid gaps during POST delay DONE by the gap length.
        trig_value = 16'h0014;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i <= 16'h1C; i++) begin
            if (i == 16'h17) begin
                repeat (3) cyc(1'b0, 1'b0, 1'b0, 16'h0);
            end
            if (i == 16'h1C) chk("gap_state_before_last", 32'(state), 32'd2);
            cyc(1'b0, 1'b0, 1'b1, 16'(i));
        end
        cap_valid = 1'b0;
        chk("gap_state", 32'(state), 32'd3);
        chk("gap_count", 32'(sample_count), 32'd16);
        chk("gap_tidx", 32'(trig_index), 32'd7);
        rd(4'd0);
        chk("gap_rd0", 32'(rd_data[15:0]), 32'h000D);
        rd(4'd15);
        chk("gap_rd15", 32'(rd_data[15:0]), 32'h001C);

        // Abort two samples into POST, then a clean re-capture.
        trig_value = 16'h0014;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i <= 16'h16; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i));
        chk("abort_pre_state", 32'(state), 32'd2);
        cyc(1'b0, 1'b1, 1'b1, 16'h0017);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        capture(16'h0003, 16'hFFFF, 16'h1C);
        check_short_capture("after_abort");

        // Reset two samples into POST, with arm asserted on the reset cycle.
        trig_value = 16'h0014;
        cyc(1'b1, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i <= 16'h16; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i));
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 16'h0014);
        rst = 1'b0;
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_count", 32'(sample_count), 32'd0);
        capture(16'h0003, 16'hFFFF, 16'h1C);
        check_short_capture("after_reset");

        // Pattern on the arm cycle is ignored; masked trigger on 0x10.
        trig_value = 16'h0010;
        trig_mask  = 16'h00F0;
        cyc(1'b1, 1'b0, 1'b1, 16'h0010);
        chk("armcyc_state", 32'(state), 32'd1);
        chk("armcyc_count", 32'(sample_count), 32'd0);
        for (int i = 0; i <= 16'h18; i++) cyc(1'b0, 1'b0, 1'b1, 16'(i));
        cap_valid = 1'b0;
        chk("mask_state", 32'(state), 32'd3);
        chk("mask_count", 32'(sample_count), 32'd16);
        chk("mask_tidx", 32'(trig_index), 32'd7);
        rd(4'd7);
        chk("mask_rd_trig", 32'(rd_data[15:0]), 32'h0010);
        rd(4'd0);
        chk("mask_rd0", 32'(rd_data[15:0]), 32'h0009);

        // Randomized phase: the compare process checks against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                trig_ch    = 1'($urandom);
                trig_value = 16'($urandom);
                trig_mask  = 16'($urandom) & 16'h000F;
            end
            rst     = ($urandom_range(0, 299) == 0);
            rd_addr = 4'($urandom);
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 39) == 0,
                $urandom_range(0, 9) < 7, 16'($urandom));
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
